id_control_unit: RTL and testbench

Instruction-decode-stage controller for the MIPS pipeline. It decodes the IF/ID instruction into the immediate extension mode that drives the sign extensor, and registers the ID/EX control word. It also sequences the front end: a one-cycle stall on load-use hazards, a bubble on taken-branch flush, a freeze under debug-unit control, and a terminal halt state on the HALT instruction.

---
 rtl/id_control_unit.sv | 176 +++++++++++++++++
 tb/tb_id_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_control_unit.sv
// id_control_unit
//
// Instruction-decode-stage controller. Decodes the IF/ID instruction into the
// sign-extensor mode and the ID/EX control word. It also sequences the front
// end: load-use stalls, taken-branch flushes, debug freeze and a terminal HALT.
//
// Ports
//   i_clk            pipeline clock, all state on the rising edge
//   i_reset_n        asynchronous active-low reset
//   i_enable         debug step enable; 0 freezes all state
//   i_instruction    IF/ID instruction
//   i_branch_taken   branch resolved taken this cycle (flush request)
//   o_extension_mode combinational immediate extension mode (00 sign, 01 zero, 10 upper)
//   o_ex_*           registered ID/EX control bits and rt of the instruction in EX
//   o_pc_write       PC load enable
//   o_if_id_write    IF/ID load enable
//   o_if_id_flush    clear IF/ID to NOP
//   o_halted         controller is in HALT
module id_control_unit #(
    parameter int unsigned BITS_INSTRUCTION = 32,
    parameter int unsigned BITS_REG_ADDR    = 5
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic [BITS_INSTRUCTION-1:0] i_instruction,
    input  logic                        i_branch_taken,
    output logic [1:0]                  o_extension_mode,
    output logic                        o_ex_reg_write,
    output logic                        o_ex_mem_read,
    output logic                        o_ex_mem_write,
    output logic                        o_ex_alu_src,
    output logic                        o_ex_reg_dst,
    output logic [BITS_REG_ADDR-1:0]    o_ex_rt,
    output logic                        o_pc_write,
    output logic                        o_if_id_write,
    output logic                        o_if_id_flush,
    output logic                        o_halted
);

    localparam logic [1:0] ExtSign  = 2'b00;
    localparam logic [1:0] ExtZero  = 2'b01;
    localparam logic [1:0] ExtUpper = 2'b10;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '{default: 1'b0};

    state_e                   state_q, state_d;
    ctrl_t                    ctrl_q, ctrl_d;
    logic [BITS_REG_ADDR-1:0] rt_q, rt_d;

    logic [5:0]               opcode;
    logic [BITS_REG_ADDR-1:0] rs;
    logic [BITS_REG_ADDR-1:0] rt;

    assign opcode = i_instruction[31:26];
    assign rs     = i_instruction[25:21];
    assign rt     = i_instruction[20:16];

    // Opcode classes
    logic is_rtype, is_imm_sign, is_imm_zero, is_lui, is_load, is_store, is_branch, is_halt;

    always_comb begin
        is_rtype    = (opcode == 6'b000000);
        is_imm_sign = (opcode == 6'b001000) || (opcode == 6'b001001) || (opcode == 6'b001010);
        is_imm_zero = (opcode == 6'b001100) || (opcode == 6'b001101) || (opcode == 6'b001110);
        is_lui      = (opcode == 6'b001111);
        is_load     = (opcode[5:2] == 4'b1000) || (opcode == 6'b100100) ||
                      (opcode == 6'b100101) || (opcode == 6'b100111);
        is_store    = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
        is_branch   = (opcode == 6'b000100) || (opcode == 6'b000101);
        is_halt     = (opcode == 6'b111111);
    end

    always_comb begin
        o_extension_mode = ExtSign;
        if (is_imm_zero) begin
            o_extension_mode = ExtZero;
        end else if (is_lui) begin
            o_extension_mode = ExtUpper;
        end
    end

    // Decoded control word; jumps, branches, HALT and unknown opcodes stay all-zero.
    ctrl_t ctrl_dec;

    always_comb begin
        ctrl_dec = CtrlBubble;
        if (is_rtype) begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.reg_dst   = 1'b1;
        end else if (is_imm_sign || is_imm_zero || is_lui) begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
        end else if (is_load) begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.mem_read  = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
        end else if (is_store) begin
            ctrl_dec.mem_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
        end
    end

    // rt is only a source operand for R-type, stores and branches.
    logic hazard;

    assign hazard = ctrl_q.mem_read && (rt_q != '0) &&
                    ((rt_q == rs) || ((rt_q == rt) && (is_rtype || is_store || is_branch)));

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        rt_d          = rt_q;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b0;

        if (!i_enable) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else if (state_q == StHalt) begin
            ctrl_d        = CtrlBubble;
            rt_d          = '0;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else if (i_branch_taken) begin
            // Flush wins over a stall and discards a HALT sitting in ID.
            ctrl_d        = CtrlBubble;
            rt_d          = '0;
            o_if_id_flush = 1'b1;
        end else if (hazard) begin
            // The bubble clears mem_read in EX, so the stall lasts one cycle.
            ctrl_d        = CtrlBubble;
            rt_d          = '0;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else begin
            ctrl_d = ctrl_dec;
            rt_d   = rt;
            if (is_halt) begin
                state_d = StHalt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StRun;
            ctrl_q  <= CtrlBubble;
            rt_q    <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            rt_q    <= rt_d;
        end
    end

    assign o_ex_reg_write = ctrl_q.reg_write;
    assign o_ex_mem_read  = ctrl_q.mem_read;
    assign o_ex_mem_write = ctrl_q.mem_write;
    assign o_ex_alu_src   = ctrl_q.alu_src;
    assign o_ex_reg_dst   = ctrl_q.reg_dst;
    assign o_ex_rt        = rt_q;
    assign o_halted       = (state_q == StHalt);

endmodule

// File: tb/tb_id_control_unit.sv
// tb_id_control_unit
//
// Directed-vector bench for id_control_unit. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked right after that, registered
// outputs after the following edge.
module tb_id_control_unit;

    localparam logic [31:0] InsOri   = 32'h3421FFFF;  // ori  $1,$1,0xffff
    localparam logic [31:0] InsLui   = 32'h3C018000;  // lui  $1,0x8000
    localparam logic [31:0] InsAddi  = 32'h2021FFFF;  // addi $1,$1,-1
    localparam logic [31:0] InsLw1   = 32'h8C010000;  // lw   $1,0($0)
    localparam logic [31:0] InsLw0   = 32'h8C000000;  // lw   $0,0($0)
    localparam logic [31:0] InsAdd   = 32'h00231020;  // add  $2,$1,$3
    localparam logic [31:0] InsAdd0  = 32'h00001020;  // add  $2,$0,$0
    localparam logic [31:0] InsSw    = 32'hAC410000;  // sw   $1,0($2)
    localparam logic [31:0] InsAddiR = 32'h20410005;  // addi $1,$2,5 (writes rt, no read)
    localparam logic [31:0] InsHalt  = 32'hFC000000;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [31:0] instruction;
    logic        branch_taken;
    logic [1:0]  extension_mode;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
    logic [4:0]  ex_rt;
    logic        pc_write, if_id_write, if_id_flush, halted;

    int checks;
    int errors;

    id_control_unit #(
        .BITS_INSTRUCTION(32),
        .BITS_REG_ADDR   (5)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_enable        (enable),
        .i_instruction   (instruction),
        .i_branch_taken  (branch_taken),
        .o_extension_mode(extension_mode),
        .o_ex_reg_write  (ex_reg_write),
        .o_ex_mem_read   (ex_mem_read),
        .o_ex_mem_write  (ex_mem_write),
        .o_ex_alu_src    (ex_alu_src),
        .o_ex_reg_dst    (ex_reg_dst),
        .o_ex_rt         (ex_rt),
        .o_pc_write      (pc_write),
        .o_if_id_write   (if_id_write),
        .o_if_id_flush   (if_id_flush),
        .o_halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed ID/EX word {reg_write, mem_read, mem_write, alu_src, reg_dst, rt}
    function automatic logic [31:0] ex_word();
        return {22'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_rt};
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] c, input logic [4:0] rt);
        return {22'd0, c, rt};
    endfunction

    // Front-end enables {pc_write, if_id_write, if_id_flush}
    function automatic logic [31:0] fe();
        return {29'd0, pc_write, if_id_write, if_id_flush};
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        enable       = 1'b1;
        instruction  = 32'h0;
        branch_taken = 1'b0;
        #12;
        check("reset_ex", ex_word(), 32'h0);
        check("reset_fe", fe(), 32'h6);
        check("reset_halted", {31'd0, halted}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Extension modes and immediate control words
        instruction = InsOri;
        #1 check("ext_ori", {30'd0, extension_mode}, 32'h1);
        tick();
        instruction = InsLui;
        #1 check("ext_lui", {30'd0, extension_mode}, 32'h2);
        check("ex_ori", ex_word(), mk(5'b10010, 5'd1));
        tick();
        instruction = InsAddi;
        #1 check("ext_addi", {30'd0, extension_mode}, 32'h0);
        check("ex_lui", ex_word(), mk(5'b10010, 5'd1));
        tick();
        check("ex_addi", ex_word(), mk(5'b10010, 5'd1));

        // Load-use on rs
        instruction = InsLw1;
        tick();
        check("ex_lw", ex_word(), mk(5'b11010, 5'd1));
        instruction = InsAdd;
        #1 check("stall_fe", fe(), 32'h0);
        tick();
        check("stall_bubble", ex_word(), 32'h0);
        check("stall_release_fe", fe(), 32'h6);
        tick();
        check("ex_add", ex_word(), mk(5'b10001, 5'd3));

        // Load of $0 never stalls
        instruction = InsLw0;
        tick();
        instruction = InsAdd0;
        #1 check("lw0_no_stall", fe(), 32'h6);
        tick();
        check("ex_add0", ex_word(), mk(5'b10001, 5'd0));

        // Load-use on rt of a store
        instruction = InsLw1;
        tick();
        instruction = InsSw;
        #1 check("sw_stall_fe", fe(), 32'h0);
        tick();
        check("sw_bubble", ex_word(), 32'h0);
        tick();
        check("ex_sw", ex_word(), mk(5'b00110, 5'd1));

        // rt match on an I-type ALU op is not a hazard
        instruction = InsLw1;
        tick();
        instruction = InsAddiR;
        #1 check("addi_rt_no_stall", fe(), 32'h6);
        tick();
        check("ex_addi_r", ex_word(), mk(5'b10010, 5'd1));

        // Flush beats stall
        instruction = InsLw1;
        tick();
        instruction  = InsAdd;
        branch_taken = 1'b1;
        #1 check("flush_fe", fe(), 32'h7);
        tick();
        branch_taken = 1'b0;
        check("flush_bubble", ex_word(), 32'h0);
        instruction = InsOri;
        tick();

        // Freeze during a pending stall
        instruction = InsLw1;
        tick();
        instruction = InsAdd;
        enable      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("freeze_fe", fe(), 32'h0);
            check("freeze_ex", ex_word(), mk(5'b11010, 5'd1));
            tick();
        end
        enable = 1'b1;
        #1 check("unfreeze_stall_fe", fe(), 32'h0);
        tick();
        check("unfreeze_bubble", ex_word(), 32'h0);
        tick();
        check("unfreeze_ex_add", ex_word(), mk(5'b10001, 5'd3));

        // HALT under flush is discarded
        instruction  = InsHalt;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("halt_flushed", {31'd0, halted}, 32'h0);

        // HALT is terminal
        tick();
        check("halted", {31'd0, halted}, 32'h1);
        instruction = InsAdd;
        for (int i = 0; i < 10; i++) begin
            #1 check("halt_fe", fe(), 32'h0);
            tick();
        end
        check("halt_still", {31'd0, halted}, 32'h1);
        check("halt_bubble", ex_word(), 32'h0);

        // Asynchronous reset out of HALT
        #2 reset_n = 1'b0;
        #1 check("rst_halted", {31'd0, halted}, 32'h0);
        check("rst_ex", ex_word(), 32'h0);
        instruction = 32'h0;
        #1 check("rst_fe", fe(), 32'h6);
        reset_n = 1'b1;
        tick();
        check("run_after_rst", {31'd0, halted}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
